uart_hex_echo: RTL and testbench
================================

UART_HEX_ECHO -- requirements
Module: uart_hex_echo

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, receive-byte FIFO entries; power of two, minimum 2.
REQ-002 Parameter APPEND_CRLF, default 1: 1 emits 0x0D 0x0A after each byte; 0 emits a single 0x20.
REQ-003 Parameter ACK_TIMEOUT, default 4096: clk cycles to wait for tx_busy high after tx_start.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 rx_data  in  8  received byte, valid with rx_valid.
REQ-008 rx_valid  in  1  receiver byte-ready strobe.
REQ-009 tx_busy  in  1  transmitter busy flag.
REQ-010 tx_start  out  1  one-cycle request to the transmitter.
REQ-011 tx_data  out  8  ASCII character for the transmitter; stable from tx_start until tx_busy falls.
REQ-012 overflow  out  1  sticky flag: a received byte was dropped.
REQ-013 fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 idle  out  1  high when the FSM is in IDLE and the FIFO is empty.

Function
REQ-015 Each 0->1 transition of rx_valid (registered edge detect) SHALL push rx_data into the FIFO, one push per edge, with 1-cycle latency to fifo_count.
REQ-016 A push when full SHALL drop the byte and set overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-017 Simultaneous push and pop SHALL leave fifo_count unchanged. Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 FSM states SHALL be IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE.
REQ-019 IDLE->LOAD when the FIFO is non-empty and tx_busy=0. LOAD SHALL pop one byte and reset char index to 0.
REQ-020 Char sequence per byte: index 0 = hex(upper nibble), 1 = hex(lower nibble), then 0x0D, 0x0A (APPEND_CRLF=1) or 0x20 (APPEND_CRLF=0).
REQ-021 hex(n) SHALL be 0x30+n for n<=9 and 0x41+(n-10) for n>=10, uppercase only.
REQ-022 SEND SHALL drive tx_data and pulse tx_start for exactly one cycle, then go to WAIT_ACK.
REQ-023 WAIT_ACK->WAIT_DONE on tx_busy=1. If ACK_TIMEOUT cycles elapse without it, go to SEND and reissue the same character.
REQ-024 WAIT_DONE: on tx_busy=0, advance char index. After the last character go to IDLE, otherwise go to SEND.
REQ-025 tx_start SHALL never assert while tx_busy=1 or outside SEND.
REQ-026 FIFO pushes SHALL continue in every FSM state.

Reset
REQ-027 Reset SHALL clear FIFO pointers, fifo_count=0, overflow=0, tx_start=0, tx_data=0x00, FSM=IDLE, char index=0, timeout counter=0, and the rx_valid edge register=0.
REQ-028 Reset mid-character SHALL abandon the byte in flight and discard FIFO contents, with no tx_start in the cycle after deassertion.
REQ-029 overflow SHALL clear only on reset.

Structure
REQ-030 The shared package uart_pkg SHALL hold the ASCII constants (0x30, 0x41, 0x0D, 0x0A, 0x20) and the FSM state encoding.
REQ-031 The FIFO SHALL be a sub-module uart_byte_fifo (push/pop/full/empty/count), reusable on the transmit path.

Verification
REQ-032 Push 0x11, tx model raises busy 2 cycles after start and holds it 10 cycles -> tx_data sequence 0x31, 0x31, 0x0D, 0x0A, four tx_start pulses, idle=1 at end.
REQ-033 APPEND_CRLF=0, push 0xAF -> 0x41, 0x46, 0x20.
REQ-034 tx_busy held 1, 17 rx_valid edges with bytes 0x00..0x10 -> fifo_count=16, overflow=1; after busy released the output sequence is 0x00..0x0F only.
REQ-035 tx model ignores the first tx_start -> a second tx_start with an identical tx_data occurs exactly ACK_TIMEOUT+1 cycles after the first.
REQ-036 Assert rst while in WAIT_DONE with 3 bytes queued -> all outputs reset in the same cycle, fifo_count=0, no tx_start after release.
REQ-037 rx_valid held high 20 cycles -> exactly one push.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART hex-echo blocks.
//   - ASCII constants used to build the echoed text.
//   - FSM state encoding for the transmit sequencer.
//   - hex_char(): 4-bit nibble to uppercase ASCII hex digit.
package uart_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] nibble);
    logic [7:0] n8;
    n8 = {4'h0, nibble};
    if (nibble <= 4'd9) begin
      hex_char = ASCII_ZERO + n8;
    end else begin
      hex_char = ASCII_A + (n8 - 8'd10);
    end
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous FIFO with pointer wrap modulo DEPTH.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, wr_data     write request and data (ignored when full unless popping)
//   pop, rd_data      read request; rd_data shows the head entry (show-ahead)
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
// DEPTH must be a power of two, minimum 2.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign do_push = push & (~full | do_pop);

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg];

endmodule

// File: rtl/uart_hex_echo.sv
// uart_hex_echo: echoes each received byte as two uppercase hex digits
// followed by CR LF (APPEND_CRLF=1) or a single space (APPEND_CRLF=0).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rx_data      received byte, captured on the rising edge of rx_valid
//   rx_valid     receiver byte-ready strobe
//   tx_busy      transmitter busy flag
//   tx_start     one-cycle transmit request
//   tx_data      character to send, held until the next character
//   overflow     sticky: a received byte was dropped because the FIFO was full
//   fifo_count   receive FIFO occupancy
//   idle         sequencer idle and FIFO empty
module uart_hex_echo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter bit APPEND_CRLF = 1'b1,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle
);

  localparam int         TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [1:0] LAST_IDX = APPEND_CRLF ? 2'd3 : 2'd2;

  state_t      state_reg, state_next;
  logic [7:0]  byte_reg, byte_next;
  logic [1:0]  idx_reg, idx_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        rx_valid_reg;
  logic        overflow_reg;

  logic        push;
  logic        pop;
  logic [7:0]  fifo_rd;
  logic        fifo_full;
  logic        fifo_empty;

  // Character at position idx of the echo sequence for one byte.
  function automatic logic [7:0] char_at(input logic [7:0] b, input logic [1:0] idx);
    case (idx)
      2'd0:    char_at = hex_char(b[7:4]);
      2'd1:    char_at = hex_char(b[3:0]);
      2'd2:    char_at = APPEND_CRLF ? ASCII_CR : ASCII_SPACE;
      default: char_at = ASCII_LF;
    endcase
  endfunction

  // One push per rising edge of rx_valid, however long it stays high.
  assign push = rx_valid & ~rx_valid_reg;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (rx_data),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      byte_reg     <= '0;
      idx_reg      <= '0;
      timer_reg    <= '0;
      tx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_reg     <= byte_next;
      idx_reg      <= idx_next;
      timer_reg    <= timer_next;
      tx_data_reg  <= tx_data_next;
      rx_valid_reg <= rx_valid;
      // Dropped only when full and not popping in the same cycle.
      if (push && fifo_full && !pop) overflow_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    byte_next    = byte_reg;
    idx_next     = idx_reg;
    timer_next   = timer_reg;
    tx_data_next = tx_data_reg;
    pop          = 1'b0;
    tx_start     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && !tx_busy) state_next = LOAD;
      end
      LOAD: begin
        // Only reachable with a non-empty FIFO, so the head is valid here.
        pop          = 1'b1;
        byte_next    = fifo_rd;
        idx_next     = 2'd0;
        timer_next   = '0;
        tx_data_next = char_at(fifo_rd, 2'd0);
        state_next   = SEND;
      end
      SEND: begin
        // Hold the request back while the transmitter still reports busy.
        if (!tx_busy) begin
          tx_start   = 1'b1;
          timer_next = '0;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == TW'(ACK_TIMEOUT - 1)) begin
          // No acknowledge: resend the same character (tx_data unchanged).
          timer_next = '0;
          state_next = SEND;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            idx_next     = idx_reg + 2'd1;
            tx_data_next = char_at(byte_reg, idx_reg + 2'd1);
            state_next   = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_data  = tx_data_reg;
  assign overflow = overflow_reg;
  assign idle     = (state_reg == IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_hex_echo.sv
module tb_uart_hex_echo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] rx_data    [2];
  logic       rx_valid   [2];
  logic       force_busy [2];
  int         ignore_at  [2];
  logic       tx_busy    [2];
  logic       tx_start   [2];
  logic [7:0] tx_data    [2];
  logic       overflow   [2];
  logic [4:0] fifo_count [2];
  logic       idle       [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_hex_echo #(.FIFO_DEPTH(16), .APPEND_CRLF(1'b1), .ACK_TIMEOUT(4096)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .overflow(overflow[0]), .fifo_count(fifo_count[0]), .idle(idle[0]));

  uart_hex_echo #(.FIFO_DEPTH(16), .APPEND_CRLF(1'b0), .ACK_TIMEOUT(8)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .overflow(overflow[1]), .fifo_count(fifo_count[1]), .idle(idle[1]));

  // Transmitter model per instance: busy rises 2 cycles after an accepted
  // start and stays high 10 cycles; the start numbered ignore_at is ignored.
  // Every start is logged with its data and cycle number.
  for (genvar gi = 0; gi < 2; gi++) begin : g_tx
    logic       busy_m  = 1'b0;
    int         dly     = 0;
    int         hold    = 0;
    int         n_start = 0;
    int         viol    = 0;
    logic [7:0] ch [512];
    int         at [512];

    always @(posedge clk) begin
      if (tx_start[gi]) begin
        if (n_start < 512) begin
          ch[n_start] <= tx_data[gi];
          at[n_start] <= cyc;
        end
        n_start <= n_start + 1;
        if (tx_busy[gi]) viol <= viol + 1;
      end
    end

    always @(posedge clk) begin
      if (rst) begin
        busy_m <= 1'b0;
        dly    <= 0;
        hold   <= 0;
      end else if (tx_start[gi] && n_start != ignore_at[gi]) begin
        dly <= 2;
      end else if (dly > 0) begin
        dly <= dly - 1;
        if (dly == 1) begin
          busy_m <= 1'b1;
          hold   <= 10;
        end
      end else if (hold > 0) begin
        hold <= hold - 1;
        if (hold == 1) busy_m <= 1'b0;
      end
    end

    assign tx_busy[gi] = busy_m | force_busy[gi];
  end

  function automatic int n_of(int k);
    return (k == 0) ? g_tx[0].n_start : g_tx[1].n_start;
  endfunction
  function automatic int ch_of(int k, int i);
    return (k == 0) ? int'(g_tx[0].ch[i]) : int'(g_tx[1].ch[i]);
  endfunction
  function automatic int at_of(int k, int i);
    return (k == 0) ? g_tx[0].at[i] : g_tx[1].at[i];
  endfunction
  function automatic int viol_of(int k);
    return (k == 0) ? g_tx[0].viol : g_tx[1].viol;
  endfunction

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input int k, input logic [7:0] d);
    @(negedge clk);
    rx_data[k]  = d;
    rx_valid[k] = 1'b1;
    @(negedge clk);
    rx_valid[k] = 1'b0;
  endtask

  task automatic wait_starts(input int k, input int target, input int budget, input string name);
    int n = 0;
    while (n_of(k) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_starts_reached"}, int'(n_of(k) >= target), 1);
  endtask

  task automatic wait_idle(input int k, input int budget, input string name);
    int n = 0;
    while (!(idle[k] && !tx_busy[k]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, int'(idle[k]), 1);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  vec_t vt [6];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    int exp_digit;
    vt[0] = '{8'h11, 8'h31, 8'h31};
    vt[1] = '{8'h00, 8'h30, 8'h30};
    vt[2] = '{8'hFF, 8'h46, 8'h46};
    vt[3] = '{8'h9A, 8'h39, 8'h41};
    vt[4] = '{8'hA9, 8'h41, 8'h39};
    vt[5] = '{8'h5C, 8'h35, 8'h43};

    for (int k = 0; k < 2; k++) begin
      rx_data[k]    = 8'h00;
      rx_valid[k]   = 1'b0;
      force_busy[k] = 1'b0;
      ignore_at[k]  = -1;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_start", int'(tx_start[0]), 0);
    check("rst_tx_data", int'(tx_data[0]), 8'h00);
    check("rst_fifo_count", int'(fifo_count[0]), 0);
    check("rst_overflow", int'(overflow[0]), 0);
    check("rst_idle", int'(idle[0]), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table: single byte, CRLF mode.
    for (int i = 0; i < 6; i++) begin
      base = n_of(0);
      push(0, vt[i].din);
      wait_starts(0, base + 4, 300, "tbl");
      wait_idle(0, 100, "tbl");
      check("tbl_start_count", n_of(0) - base, 4);
      check("tbl_hi", ch_of(0, base), vt[i].hi);
      check("tbl_lo", ch_of(0, base + 1), vt[i].lo);
      check("tbl_cr", ch_of(0, base + 2), 8'h0D);
      check("tbl_lf", ch_of(0, base + 3), 8'h0A);
      $display("byte 0x%02h -> %02h %02h %02h %02h", vt[i].din, ch_of(0, base),
               ch_of(0, base + 1), ch_of(0, base + 2), ch_of(0, base + 3));
    end

    // rx_valid held high for 20 cycles: a single push.
    force_busy[0] = 1'b1;
    base = n_of(0);
    @(negedge clk);
    rx_data[0]  = 8'h7E;
    rx_valid[0] = 1'b1;
    repeat (20) @(negedge clk);
    rx_valid[0] = 1'b0;
    @(negedge clk);
    check("held_valid_count", int'(fifo_count[0]), 1);
    force_busy[0] = 1'b0;
    wait_starts(0, base + 4, 300, "held");
    wait_idle(0, 100, "held");
    check("held_start_count", n_of(0) - base, 4);
    check("held_hi", ch_of(0, base), 8'h37);
    check("held_lo", ch_of(0, base + 1), 8'h45);
    $display("held rx_valid byte 0x7E -> %02h %02h", ch_of(0, base), ch_of(0, base + 1));

    // Fill to 16 with the transmitter busy, then one more to overflow.
    force_busy[0] = 1'b1;
    base = n_of(0);
    for (int i = 0; i < 16; i++) push(0, 8'(i));
    @(negedge clk);
    check("fill16_count", int'(fifo_count[0]), 16);
    check("fill16_overflow", int'(overflow[0]), 0);
    push(0, 8'h10);
    @(negedge clk);
    check("fill17_count", int'(fifo_count[0]), 16);
    check("fill17_overflow", int'(overflow[0]), 1);
    force_busy[0] = 1'b0;
    wait_starts(0, base + 64, 3000, "drain");
    wait_idle(0, 100, "drain");
    check("drain_start_count", n_of(0) - base, 64);
    for (int i = 0; i < 16; i++) begin
      exp_digit = (i < 10) ? (8'h30 + i) : (8'h41 + i - 10);
      check("drain_hi", ch_of(0, base + 4 * i), 8'h30);
      check("drain_lo", ch_of(0, base + 4 * i + 1), exp_digit);
      check("drain_cr", ch_of(0, base + 4 * i + 2), 8'h0D);
      check("drain_lf", ch_of(0, base + 4 * i + 3), 8'h0A);
    end
    $display("overflow drain: %0d characters sent", n_of(0) - base);
    check("overflow_sticky", int'(overflow[0]), 1);

    // Reset while in WAIT_DONE with three bytes queued.
    for (int j = 0; j < 4; j++) push(0, 8'hC0 + 8'(j));
    for (int n = 0; n < 50 && !tx_busy[0]; n++) @(negedge clk);
    check("midrst_busy_seen", int'(tx_busy[0]), 1);
    repeat (2) @(negedge clk);
    check("midrst_queued", int'(fifo_count[0]), 3);
    rst = 1'b1;
    #1;
    check("midrst_tx_start", int'(tx_start[0]), 0);
    check("midrst_tx_data", int'(tx_data[0]), 8'h00);
    check("midrst_fifo_count", int'(fifo_count[0]), 0);
    check("midrst_overflow", int'(overflow[0]), 0);
    check("midrst_idle", int'(idle[0]), 1);
    @(negedge clk);
    rst = 1'b0;
    base = n_of(0);
    repeat (40) @(negedge clk);
    check("postrst_no_start", n_of(0) - base, 0);
    check("postrst_count", int'(fifo_count[0]), 0);
    $display("reset in WAIT_DONE: starts after release = %0d", n_of(0) - base);

    // Space-terminated mode.
    base = n_of(1);
    push(1, 8'hAF);
    wait_starts(1, base + 3, 300, "sp");
    wait_idle(1, 100, "sp");
    check("sp_start_count", n_of(1) - base, 3);
    check("sp_hi", ch_of(1, base), 8'h41);
    check("sp_lo", ch_of(1, base + 1), 8'h46);
    check("sp_space", ch_of(1, base + 2), 8'h20);
    $display("byte 0xAF (space mode) -> %02h %02h %02h", ch_of(1, base),
             ch_of(1, base + 1), ch_of(1, base + 2));

    // First start unacknowledged: resend after ACK_TIMEOUT+1 = 9 cycles.
    base = n_of(1);
    ignore_at[1] = base;
    push(1, 8'h3C);
    wait_starts(1, base + 4, 400, "to");
    wait_idle(1, 100, "to");
    check("to_start_count", n_of(1) - base, 4);
    check("to_gap", at_of(1, base + 1) - at_of(1, base), 9);
    check("to_first", ch_of(1, base), 8'h33);
    check("to_resend", ch_of(1, base + 1), 8'h33);
    check("to_lo", ch_of(1, base + 2), 8'h43);
    check("to_space", ch_of(1, base + 3), 8'h20);
    $display("timeout resend gap = %0d cycles", at_of(1, base + 1) - at_of(1, base));

    check("no_start_while_busy0", viol_of(0), 0);
    check("no_start_while_busy1", viol_of(1), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
